// File: rtl/dmem_responder.sv
// Data-memory responder for the EX-to-MEM interface: word-organised RAM with
// byte-lane stores, sign/zero-extended loads returned one cycle after the
// request, and a one-cycle error pulse for misaligned or illegal accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ena_i,
    input  logic        mem_rw_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_rvalid_o,
    output logic        mem_err_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          legal;
    logic          wr_en;
    logic          rd_resp;
    logic          err_n;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   rd_word;
    logic [31:0]   rd_sel;
    logic [31:0]   rd_ext;
    logic [31:0]   rdata_n;

    // Address decode: upper offset bits are dropped so the RAM aliases.
    always_comb begin
        idx  = AW'((mem_addr_i - ADDR_BASE) >> 2);
        lane = mem_addr_i[1:0];
    end

    // Legality, byte enables and store-data replication for the request.
    always_comb begin
        legal     = 1'b0;
        be        = 4'b0000;
        wdata_rep = mem_wdata_i;
        wr_en     = 1'b0;
        rd_resp   = 1'b0;
        err_n     = 1'b0;
        if (mem_ena_i) begin
            case (mem_funct3_i)
                F3_B:    legal = 1'b1;
                F3_H:    legal = ~lane[0];
                F3_W:    legal = (lane == 2'b00);
                F3_BU:   legal = ~mem_rw_i;
                F3_HU:   legal = ~mem_rw_i & ~lane[0];
                default: legal = 1'b0;
            endcase
            case (mem_funct3_i[1:0])
                2'b00: begin
                    be        = 4'(4'b0001 << lane);
                    wdata_rep = {4{mem_wdata_i[7:0]}};
                end
                2'b01: begin
                    be        = lane[1] ? 4'b1100 : 4'b0011;
                    wdata_rep = {2{mem_wdata_i[15:0]}};
                end
                default: begin
                    be        = 4'b1111;
                    wdata_rep = mem_wdata_i;
                end
            endcase
            wr_en   = mem_rw_i & legal;
            rd_resp = ~mem_rw_i;
            err_n   = ~legal;
        end
    end

    // Load path: select the addressed lane and extend it to 32 bits.
    always_comb begin
        rd_word = mem[idx];
        rd_sel  = rd_word >> {lane, 3'b000};
        case (mem_funct3_i)
            F3_B:    rd_ext = {{24{rd_sel[7]}}, rd_sel[7:0]};
            F3_H:    rd_ext = {{16{rd_sel[15]}}, rd_sel[15:0]};
            F3_BU:   rd_ext = {24'h000000, rd_sel[7:0]};
            F3_HU:   rd_ext = {16'h0000, rd_sel[15:0]};
            default: rd_ext = rd_sel;
        endcase
        rdata_n = legal ? rd_ext : 32'h0000_0000;
    end

    // RAM byte-lane write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // Response registers: rdata holds until the next load response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdata_o  <= 32'h0000_0000;
            mem_rvalid_o <= 1'b0;
            mem_err_o    <= 1'b0;
        end else begin
            mem_rvalid_o <= rd_resp;
            mem_err_o    <= err_n;
            if (rd_resp) begin
                mem_rdata_o <= rdata_n;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: each request is driven on a falling
// edge and its response is checked on the following falling edge.
module tb_dmem_responder;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk;
    logic        rst;
    logic        mem_ena_i;
    logic        mem_rw_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_rvalid_o;
    logic        mem_err_o;

    int compared   = 0;
    int mismatched = 0;

    dmem_responder #(
        .DEPTH_LOG2 (10),
        .ADDR_BASE  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_ena_i    (mem_ena_i),
        .mem_rw_i     (mem_rw_i),
        .mem_funct3_i (mem_funct3_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_rdata_o  (mem_rdata_o),
        .mem_rvalid_o (mem_rvalid_o),
        .mem_err_o    (mem_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison point.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request, advance one cycle, then check the response.
    task automatic xact(input string tag, input logic e, input logic rw, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_rv, input logic [31:0] exp_rd, input logic exp_err);
        mem_ena_i    = e;
        mem_rw_i     = rw;
        mem_funct3_i = f;
        mem_addr_i   = a;
        mem_wdata_i  = wd;
        @(negedge clk);
        check({tag, ".rvalid"}, {31'd0, mem_rvalid_o}, {31'd0, exp_rv});
        check({tag, ".rdata"},  mem_rdata_o, exp_rd);
        check({tag, ".err"},    {31'd0, mem_err_o}, {31'd0, exp_err});
    endtask

    initial begin
        // Reset asserted while a load of 0x10 is being presented.
        rst          = 1'b0;
        mem_ena_i    = 1'b1;
        mem_rw_i     = 1'b0;
        mem_funct3_i = W;
        mem_addr_i   = 32'h10;
        mem_wdata_i  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        mem_ena_i = 1'b0;
        @(negedge clk);
        check("reset.rvalid", {31'd0, mem_rvalid_o}, 32'd0);
        check("reset.rdata",  mem_rdata_o, 32'h0);
        check("reset.err",    {31'd0, mem_err_o}, 32'd0);

        // Word store then loads of every size.
        xact("sw_dead",   1, 1, W,  32'h20, 32'hDEADBEEF, 0, 32'h0000_0000, 0);
        xact("lw_20",     1, 0, W,  32'h20, 32'h0,        1, 32'hDEADBEEF, 0);
        xact("lb_21",     1, 0, B,  32'h21, 32'h0,        1, 32'hFFFFFFBE, 0);
        xact("lbu_21",    1, 0, BU, 32'h21, 32'h0,        1, 32'h000000BE, 0);
        xact("lh_22",     1, 0, H,  32'h22, 32'h0,        1, 32'hFFFFDEAD, 0);
        xact("lhu_20",    1, 0, HU, 32'h20, 32'h0,        1, 32'h0000BEEF, 0);

        // Partial stores.
        xact("sb_23",     1, 1, B,  32'h23, 32'h12,       0, 32'h0000BEEF, 0);
        xact("lw_sb",     1, 0, W,  32'h20, 32'h0,        1, 32'h12ADBEEF, 0);
        xact("sh_20",     1, 1, H,  32'h20, 32'h5678,     0, 32'h12ADBEEF, 0);
        xact("lw_sh",     1, 0, W,  32'h20, 32'h0,        1, 32'h12AD5678, 0);
        xact("lbu_23",    1, 0, BU, 32'h23, 32'h0,        1, 32'h00000012, 0);
        xact("lb_22",     1, 0, B,  32'h22, 32'h0,        1, 32'hFFFFFFAD, 0);

        // Misaligned and illegal accesses.
        xact("lw_mis",    1, 0, W,  32'h22, 32'h0,        1, 32'h0000_0000, 1);
        xact("sh_mis",    1, 1, H,  32'h21, 32'hFFFF,     0, 32'h0000_0000, 1);
        xact("lw_after",  1, 0, W,  32'h20, 32'h0,        1, 32'h12AD5678, 0);
        xact("lf3_011",   1, 0, 3'b011, 32'h20, 32'h0,    1, 32'h0000_0000, 1);
        xact("sbu_ill",   1, 1, BU, 32'h20, 32'hFF,       0, 32'h0000_0000, 1);
        xact("lw_keep",   1, 0, W,  32'h20, 32'h0,        1, 32'h12AD5678, 0);

        // Idle cycle carrying a would-be store must not write or respond.
        xact("idle",      0, 1, W,  32'h20, 32'h0,        0, 32'h12AD5678, 0);
        xact("lw_idle",   1, 0, W,  32'h20, 32'h0,        1, 32'h12AD5678, 0);

        // Aliasing and load-then-store ordering.
        xact("sw_alias",  1, 1, W,  32'h1000, 32'hA5A5A5A5, 0, 32'h12AD5678, 0);
        xact("lw_alias",  1, 0, W,  32'h0,  32'h0,        1, 32'hA5A5A5A5, 0);
        xact("lw_old",    1, 0, W,  32'h0,  32'h0,        1, 32'hA5A5A5A5, 0);
        xact("sw_zero",   1, 1, W,  32'h0,  32'h0,        0, 32'hA5A5A5A5, 0);
        xact("lw_new",    1, 0, W,  32'h0,  32'h0,        1, 32'h0000_0000, 0);

        mem_ena_i = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the EX-to-MEM data-memory interface: accepts one load/store request per cycle from the pipeline and returns load data one cycle later.
- The one-cycle latency matches the pipeline's single-cycle load stall.
- Holds a synchronous word-organised data RAM, performs byte-lane stores, and sign/zero-extends loads.
- Flags misaligned or illegal accesses.

Parameters:
- DEPTH_LOG2, 10, log2 of number of 32-bit words (default 1024 words = 4 KiB).
- ADDR_BASE, 32'h0000_0000, base byte address; the word index is computed from (addr - ADDR_BASE).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- mem_ena_i  input  1  request valid this cycle
- mem_rw_i  input  1  0 = read (`MEM_READ), 1 = write
- mem_funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only)
- mem_addr_i  input  32  byte address
- mem_wdata_i  input  32  store data, right-aligned
- mem_rdata_o  output  32  extended load data
- mem_rvalid_o  output  1  one-cycle pulse: mem_rdata_o carries a new load result
- mem_err_o  output  1  one-cycle pulse: previous-cycle request was misaligned or illegal

Behaviour:
- Reset (rst=0, async): mem_rdata_o=0, mem_rvalid_o=0, mem_err_o=0, pending-read registers cleared. RAM contents are not reset. A read accepted in the cycle reset asserts produces no response.
- Word index = (addr - ADDR_BASE)[DEPTH_LOG2+1:2]. Upper bits are ignored, so out-of-range addresses alias (wrap-around).
- Alignment check, evaluated on the request cycle:
  - B/BU: always legal.
  - H/HU: addr[0]=0.
  - W: addr[1:0]=00.
  - funct3 011, 110, 111 are illegal. Store funct3 100/101 is illegal.
- Store (ena=1, rw=1, legal):
  - Byte enables from size and addr[1:0]: B -> 1 lane; H -> lanes {1,0} or {3,2}; W -> all.
  - wdata is replicated into the selected lanes and written at the rising edge of the request cycle.
  - No rvalid pulse.
- Load (ena=1, rw=0, legal):
  - RAM read synchronously at the request edge; funct3 and addr[1:0] are registered alongside.
  - Next cycle: selected byte/half is shifted down and sign-extended (B, H) or zero-extended (BU, HU), driven on mem_rdata_o with mem_rvalid_o=1.
  - Latency is exactly 1 cycle.
- Illegal/misaligned request:
  - No RAM write.
  - Next cycle: mem_err_o=1. For a load, also mem_rvalid_o=1 with mem_rdata_o=0 so the pipeline never hangs.
- mem_rdata_o holds its last value until the next load response. Stores and idle cycles do not change it.
- Back-to-back requests are accepted every cycle; there is no backpressure.
- Ordering:
  - Store at cycle N then load of the same word at N+1: the load returns the new data.
  - Load at N then store at N+1 to the same word: the load returns the old data.
- ena=0: no RAM access. rvalid and err are 0 next cycle.
- X on mem_rw_i/funct3 while ena=0 must not affect state.

Test Plan:
- Reset with rst=0 mid-load (load at addr 0x10 issued same cycle) -> after release: rvalid=0, rdata=0, err=0; no response emitted.
- SW 0xDEADBEEF @0x20, then LW @0x20 next cycle -> one cycle later rvalid=1, rdata=0xDEADBEEF.
- Byte/half loads of that word:
  - LB @0x21 -> 0xFFFFFFBE
  - LBU @0x21 -> 0x000000BE
  - LH @0x22 -> 0xFFFFDEAD
  - LHU @0x20 -> 0x0000BEEF
- SB 0x12 @0x23 over 0xDEADBEEF, then LW @0x20 -> 0x12ADBEEF. SH 0x5678 @0x20, then LW -> 0x12AD5678.
- Misaligned:
  - LW @0x22 -> next cycle rvalid=1, rdata=0, err=1.
  - SH @0x21 with 0xFFFF -> err=1, and a following LW @0x20 still returns 0x12AD5678.
- Aliasing and ordering:
  - SW 0xA5A5A5A5 @0x1000 (DEPTH_LOG2=10), then LW @0x0000 -> 0xA5A5A5A5.
  - LW @0x0 then SW 0x0 @0x0 on consecutive cycles -> load returns 0xA5A5A5A5.
